// File: rtl/part_sram_sync_pkg.sv
// Shared definitions for the part_sram_sync memory: the sequencer state encoding.
package part_sram_sync_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_CLEAR = 2'd1,
    S_READY = 2'd2
  } state_e;

endpackage

// File: rtl/part_sram_sync.sv
// Parametrised synchronous SRAM, one write port and one registered read port,
// with a hardware clear sequencer that fills the array with INIT_VAL.
module part_sram_sync
  import part_sram_sync_pkg::*;
#(
  parameter int unsigned     AW             = 10,
  parameter int unsigned     DW             = 32,
  parameter logic [DW-1:0]   INIT_VAL       = '0,
  parameter int unsigned     CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          ready,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem [0:2**AW-1];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wdata  = wdata;
    case (state_q)
      S_RST: begin
        clr_addr_d = '0;
        state_d    = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      end
      S_CLEAR: begin
        // Clear owns the single write port; user traffic is dropped.
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = INIT_VAL;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = S_READY;
      end
      S_READY: begin
        mem_we = we;
        if (re) begin
          rvalid_d = 1'b1;
          if (we && (waddr == raddr)) rdata_d = wdata;
          else if ($isunknown(raddr)) rdata_d = '0;
          else                        rdata_d = mem[raddr];
        end
        // The access in this cycle completes; clearing begins next edge.
        if (clr) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = S_RST;
    endcase
    ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RST;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array contents survive reset; only the clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_part_sram_sync.sv
// Directed bench for part_sram_sync: clear sequencing, read/write, bypass, reset abort.
module tb_part_sram_sync;

  logic       clk;
  logic       reset, clr, we, re;
  logic [3:0] waddr, raddr;
  logic [7:0] wdata;
  logic       ready, rvalid;
  logic [7:0] rdata;

  logic       reset_n, clr_n, we_n, re_n;
  logic [3:0] waddr_n, raddr_n;
  logic [7:0] wdata_n;
  logic       ready_n, rvalid_n;
  logic [7:0] rdata_n;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [3:0] raddr;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  part_sram_sync #(.AW(4), .DW(8), .INIT_VAL(8'hA5), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
  );

  part_sram_sync #(.AW(4), .DW(8), .INIT_VAL(8'h00), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset(reset_n), .clr(clr_n), .ready(ready_n),
    .we(we_n), .waddr(waddr_n), .wdata(wdata_n),
    .re(re_n), .raddr(raddr_n), .rdata(rdata_n), .rvalid(rvalid_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic w, logic [3:0] wa, logic [7:0] wd,
                              logic r, logic [3:0] ra, logic ev, logic [7:0] ed);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.re = r; v.raddr = ra; v.exp_rvalid = ev; v.exp_rdata = ed;
    return v;
  endfunction

  task automatic read_all_init(input string name);
    we = 1'b0;
    for (int a = 0; a < 16; a++) begin
      re = 1'b1; raddr = 4'(a);
      step();
      check({name, "_rvalid"}, {7'd0, rvalid}, 8'd1);
      check({name, "_rdata"}, rdata, 8'hA5);
    end
    re = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    reset_n = 1'b1; clr_n = 1'b0; we_n = 1'b0; re_n = 1'b0;
    waddr_n = '0; raddr_n = '0; wdata_n = '0;

    // Reset state
    repeat (2) step();
    check("rst_ready", {7'd0, ready}, 8'd0);
    check("rst_rvalid", {7'd0, rvalid}, 8'd0);
    check("rst_rdata", rdata, 8'h00);

    // Power-up clear: 1 S_RST edge + 16 clear edges
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("init_ready_low", {7'd0, ready}, 8'd0);
    end
    step();
    check("init_ready_high", {7'd0, ready}, 8'd1);
    read_all_init("init_read");

    // Table-driven read/write/bypass vectors
    vecs.push_back(mk(1, 4'd5,  8'h3C, 0, 4'd0,  0, 8'hA5));
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 4'd5,  1, 8'h3C));
    vecs.push_back(mk(0, 4'd0,  8'h00, 0, 4'd0,  0, 8'h3C));
    vecs.push_back(mk(1, 4'd7,  8'h11, 1, 4'd7,  1, 8'h11));
    vecs.push_back(mk(1, 4'd7,  8'h22, 1, 4'd6,  1, 8'hA5));
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 4'd7,  1, 8'h22));
    vecs.push_back(mk(1, 4'd6,  8'h99, 1, 4'd7,  1, 8'h22));
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 4'd6,  1, 8'h99));
    vecs.push_back(mk(1, 4'd15, 8'hF0, 0, 4'd0,  0, 8'h99));
    vecs.push_back(mk(1, 4'd0,  8'h0F, 1, 4'd15, 1, 8'hF0));
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  1, 8'h0F));
    vecs.push_back(mk(1, 4'd2,  8'h77, 0, 4'd0,  0, 8'h0F));
    foreach (vecs[i]) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re = vecs[i].re; raddr = vecs[i].raddr;
      step();
      check($sformatf("vec%0d_rvalid", i), {7'd0, rvalid}, {7'd0, vecs[i].exp_rvalid});
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_ready", i), {7'd0, ready}, 8'd1);
    end

    // clr together with a write and a read: the access completes, then clearing
    clr = 1'b1; we = 1'b1; waddr = 4'd9; wdata = 8'h55; re = 1'b1; raddr = 4'd2;
    step();
    check("clr_rdata_old", rdata, 8'h77);
    check("clr_rvalid", {7'd0, rvalid}, 8'd1);
    check("clr_ready_drop", {7'd0, ready}, 8'd0);
    clr = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 8'hEE; re = 1'b1; raddr = 4'd2;
    for (int i = 1; i <= 15; i++) begin
      step();
      check("clr_ready_low", {7'd0, ready}, 8'd0);
      check("clr_rvalid_low", {7'd0, rvalid}, 8'd0);
      check("clr_rdata_hold", rdata, 8'h77);
    end
    step();
    check("clr_ready_high", {7'd0, ready}, 8'd1);
    check("clr_rvalid_end", {7'd0, rvalid}, 8'd0);
    read_all_init("clr_read");

    // Reset in the middle of a clear: async clear of outputs, restart from 0
    reset = 1'b1;
    #1;
    check("rst_async_rdata", rdata, 8'h00);
    check("rst_async_ready", {7'd0, ready}, 8'd0);
    step();
    reset = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    check("abort_ready", {7'd0, ready}, 8'd0);
    step();
    reset = 1'b0;
    we = 1'b1; waddr = 4'd3; wdata = 8'hEE; re = 1'b1; raddr = 4'd3;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("abort_ready_low", {7'd0, ready}, 8'd0);
      check("abort_rvalid_low", {7'd0, rvalid}, 8'd0);
    end
    we = 1'b0; re = 1'b0;
    step();
    check("abort_ready_high", {7'd0, ready}, 8'd1);
    read_all_init("abort_read");

    // CLEAR_ON_RESET=0: ready one edge after release, array untouched by reset
    reset_n = 1'b0;
    step();
    check("nc_ready", {7'd0, ready_n}, 8'd1);
    we_n = 1'b1; waddr_n = 4'd3; wdata_n = 8'h42;
    step();
    we_n = 1'b0; re_n = 1'b1; raddr_n = 4'd3;
    step();
    check("nc_rvalid", {7'd0, rvalid_n}, 8'd1);
    check("nc_rdata", rdata_n, 8'h42);
    re_n = 1'b0;
    reset_n = 1'b1;
    #1;
    check("nc_rst_rdata", rdata_n, 8'h00);
    check("nc_rst_ready", {7'd0, ready_n}, 8'd0);
    step();
    reset_n = 1'b0;
    step();
    check("nc_ready_again", {7'd0, ready_n}, 8'd1);
    re_n = 1'b1; raddr_n = 4'd3;
    step();
    check("nc_keep_rdata", rdata_n, 8'h42);
    re_n = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
